rtc_scan_sequencer: RTL and testbench

- Hardware sequencer that periodically snapshots the RTC and refreshes the VGA register bank without PicoBlaze involvement.
- Issues one transfer-command write, then nine register reads (time, date, timer) to the RTC bus engine.
- Each returned byte is pushed into the register bank with a one-hot hold strobe.
- Sits between the RTC bus engine (downstream of this block on the request side) and the display register bank (consumer).

---
 rtl/rtc_scan_sequencer_pkg.sv | 48 ++++
 rtl/rtc_scan_sequencer_if.sv | 33 +++
 rtl/rtc_scan_sequencer_tick.sv | 29 ++
 rtl/rtc_scan_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rtc_scan_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_scan_sequencer_pkg.sv
// Shared definitions for the RTC scan sequencer: FSM encoding, RTC register
// map walked by a scan, and the register-bank hold bit positions.
package rtc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD_REQ  = 3'd1,
        ST_CMD_WAIT = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_STORE    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam int NUM_REGS = 9;

    // Register-bank hold bit positions, in scan order.
    localparam int HOLD_SEG_HORA   = 0;
    localparam int HOLD_MIN_HORA   = 1;
    localparam int HOLD_HORA_HORA  = 2;
    localparam int HOLD_DIA_FECHA  = 3;
    localparam int HOLD_MES_FECHA  = 4;
    localparam int HOLD_JAHR_FECHA = 5;
    localparam int HOLD_SEG_TIMER  = 6;
    localparam int HOLD_MIN_TIMER  = 7;
    localparam int HOLD_HORA_TIMER = 8;

    localparam logic [3:0] LAST_INDEX = 4'(HOLD_HORA_TIMER);

    // RTC RAM address read for each scan index (time, date, timer).
    function automatic logic [7:0] addr_of(input logic [3:0] index);
        logic [7:0] addr;
        case (index)
            4'd0:    addr = 8'h21;
            4'd1:    addr = 8'h22;
            4'd2:    addr = 8'h23;
            4'd3:    addr = 8'h24;
            4'd4:    addr = 8'h25;
            4'd5:    addr = 8'h26;
            4'd6:    addr = 8'h41;
            4'd7:    addr = 8'h42;
            4'd8:    addr = 8'h43;
            default: addr = 8'h00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_scan_sequencer_if.sv
// Request/response link between the scan sequencer and the RTC bus engine.
interface rtc_scan_sequencer_if;

    // req_write / req_read are single-cycle strobes with req_addr/req_data
    // valid alongside; the engine answers every strobe with exactly one
    // single-cycle bus_done, and bus_rdata is meaningful only while bus_done
    // is high. No new strobe is issued before the previous bus_done.
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_write;
    logic       req_read;
    logic       bus_done;
    logic [7:0] bus_rdata;

    modport master (
        output req_addr,
        output req_data,
        output req_write,
        output req_read,
        input  bus_done,
        input  bus_rdata
    );

    modport slave (
        input  req_addr,
        input  req_data,
        input  req_write,
        input  req_read,
        output bus_done,
        output bus_rdata
    );

endinterface

// File: rtl/rtc_scan_sequencer_tick.sv
// Free-running refresh divider: one tick every REFRESH_CYCLES clocks while
// enabled, counter parked at zero while disabled.
module rtc_scan_tick #(
    parameter int REFRESH_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rtc_scan_sequencer.sv
// Periodically latches the RTC into its RAM, reads back the nine time/date/
// timer registers and loads them into the display register bank.
module rtc_scan_sequencer
    import rtc_scan_pkg::*;
#(
    parameter int         REFRESH_CYCLES = 10_000_000,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] CMD_ADDR       = 8'hF0,
    parameter logic [7:0] CMD_DATA       = 8'hF2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   force_scan,
    rtc_scan_sequencer_if.master   bus,
    output logic [7:0]             wr_data,
    output logic [NUM_REGS-1:0]    hold,
    output logic                   busy,
    output logic                   scan_done,
    output logic                   timeout_err,
    output state_t                 state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    index_q;
    logic          pending_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    wr_data_q;

    logic tick;
    logic start;
    logic in_wait;
    logic tcnt_last;
    logic timeout_hit;

    rtc_scan_tick #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign in_wait   = (state_q == ST_CMD_WAIT) || (state_q == ST_RD_WAIT);
    assign tcnt_last = (tcnt_q == TO_LAST);

    // Next-state logic. bus_done is only looked at in the two wait states,
    // so a stray completion anywhere else has no effect.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || force_scan) begin
                    state_d = ST_CMD_REQ;
                    start   = 1'b1;
                end
            end
            ST_CMD_REQ: state_d = ST_CMD_WAIT;
            ST_CMD_WAIT: begin
                if (bus.bus_done) begin
                    state_d = ST_RD_REQ;
                end else if (tcnt_last) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (bus.bus_done) begin
                    state_d = ST_STORE;
                end else if (tcnt_last) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_STORE: state_d = (index_q == LAST_INDEX) ? ST_DONE : ST_RD_REQ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_q <= '0;
        end else if (start) begin
            index_q <= '0;
        end else if (state_q == ST_STORE && index_q != LAST_INDEX) begin
            index_q <= index_q + 4'd1;
        end
    end

    // One-deep request memory: a start consumes it, any tick or force seen
    // while not starting (including mid-scan) queues exactly one more scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
        end else if (start) begin
            pending_q <= 1'b0;
        end else if (tick || force_scan) begin
            pending_q <= 1'b1;
        end
    end

    // Counts cycles spent in a wait state; any non-wait state rearms it, so
    // every wait begins from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
        end else if (!in_wait) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_data_q <= '0;
        end else if (state_q == ST_RD_WAIT && bus.bus_done) begin
            wr_data_q <= bus.bus_rdata;
        end
    end

    // Request outputs decode from state so they drop to zero the instant
    // reset is asserted.
    always_comb begin
        bus.req_addr  = 8'h00;
        bus.req_data  = 8'h00;
        bus.req_write = 1'b0;
        bus.req_read  = 1'b0;
        case (state_q)
            ST_CMD_REQ: begin
                bus.req_write = 1'b1;
                bus.req_addr  = CMD_ADDR;
                bus.req_data  = CMD_DATA;
            end
            ST_CMD_WAIT: begin
                bus.req_addr = CMD_ADDR;
                bus.req_data = CMD_DATA;
            end
            ST_RD_REQ: begin
                bus.req_read = 1'b1;
                bus.req_addr = addr_of(index_q);
            end
            ST_RD_WAIT: begin
                bus.req_addr = addr_of(index_q);
            end
            default: begin
                bus.req_addr = 8'h00;
            end
        endcase
    end

    always_comb begin
        hold = '0;
        if (state_q == ST_STORE) begin
            hold[index_q] = 1'b1;
        end
    end

    assign wr_data     = wr_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign scan_done   = (state_q == ST_DONE);
    assign timeout_err = timeout_hit;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rtc_scan_sequencer.sv
// Self-checking bench for rtc_scan_sequencer: a delayed bus responder, an
// output monitor that pops an expected event queue, and directed scenarios.
module tb_rtc_scan_sequencer;
  import rtc_scan_pkg::*;

  localparam int REFRESH = 50;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       enable = 1'b0;
  logic       force_scan = 1'b0;
  logic [7:0] wr_data;
  logic [8:0] hold;
  logic       busy;
  logic       scan_done;
  logic       timeout_err;
  state_t     state_dbg;

  logic       rsp_done = 1'b0;
  logic       spur_done = 1'b0;
  logic [7:0] rsp_rdata = 8'h00;

  rtc_scan_sequencer_if bus ();
  assign bus.bus_done  = rsp_done | spur_done;
  assign bus.bus_rdata = rsp_rdata;

  rtc_scan_sequencer #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CMD_ADDR(8'hF0),
    .CMD_DATA(8'hF2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .force_scan(force_scan),
    .bus(bus),
    .wr_data(wr_data),
    .hold(hold),
    .busy(busy),
    .scan_done(scan_done),
    .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0] tb_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  function automatic int idx_of(input logic [7:0] a);
    int r;
    r = 0;
    for (int i = 0; i < 9; i++) if (tb_addr[i] == a) r = i;
    return r;
  endfunction

  // Event word: {type, 3'b0, addr, data, hold}
  function automatic logic [31:0] ev(input logic [3:0] t, input logic [7:0] a,
                                     input logic [7:0] d, input logic [8:0] h);
    return {t, 3'b000, a, d, h};
  endfunction

  logic [31:0] exp_q[$];

  task automatic push_scan();
    exp_q.push_back(ev(4'd1, 8'hF0, 8'hF2, 9'd0));
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(ev(4'd2, tb_addr[i], 8'h00, 9'd0));
      exp_q.push_back(ev(4'd3, 8'h00, 8'(8'h10 + i), 9'(9'd1 << i)));
    end
    exp_q.push_back(ev(4'd4, 8'h00, 8'h00, 9'd0));
  endtask

  // ---------------- bus responder ----------------
  int         rsp_delay = 3;
  logic [7:0] drop_addr = 8'h00;
  logic       spur_store = 1'b0;
  int         rst_gen = 0;

  initial begin
    logic       is_rd;
    logic [7:0] a;
    int         gen;
    int         ix;
    forever begin
      @(negedge clk);
      if (reset && (bus.req_write || bus.req_read)) begin
        is_rd = bus.req_read;
        a     = bus.req_addr;
        gen   = rst_gen;
        ix    = idx_of(a);
        if (!(is_rd && a == drop_addr)) begin
          repeat (rsp_delay) @(posedge clk);
          #1;
          rsp_done  = 1'b1;
          rsp_rdata = is_rd ? 8'(8'h10 + ix) : 8'h00;
          @(posedge clk);
          #1;
          if (is_rd && gen == rst_gen) begin
            check_eq("hold_latency", 64'(hold), 64'(9'd1 << ix));
            check_eq("hold_wr_data", 64'(wr_data), 64'(8'h10 + ix));
          end
          if (spur_store && is_rd) begin
            @(posedge clk);
            #1;
          end
          rsp_done  = 1'b0;
          rsp_rdata = 8'h00;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int wr_count = 0;
  int rd_count = 0;
  int done_count = 0;
  int last_wr_cyc = 0;
  int last_rd_cyc = 0;
  int last_done_cyc = 0;
  int last_to_cyc = 0;
  int wr_cycs[$];

  initial begin
    logic [31:0] obs;
    forever begin
      @(negedge clk);
      obs = 32'd0;
      if (reset) begin
        if (bus.req_write) begin
          obs = ev(4'd1, bus.req_addr, bus.req_data, 9'd0);
          wr_count++;
          last_wr_cyc = cyc;
          wr_cycs.push_back(cyc);
        end else if (bus.req_read) begin
          obs = ev(4'd2, bus.req_addr, bus.req_data, 9'd0);
          rd_count++;
          last_rd_cyc = cyc;
        end else if (hold != 9'd0) begin
          obs = ev(4'd3, 8'h00, wr_data, hold);
        end else if (scan_done) begin
          obs = ev(4'd4, 8'h00, 8'h00, 9'd0);
          done_count++;
          last_done_cyc = cyc;
        end else if (timeout_err) begin
          obs = ev(4'd5, 8'h00, 8'h00, 9'd0);
          last_to_cyc = cyc;
        end
        if (obs != 32'd0) begin
          check_eq("one_hot_pulses",
                   64'($countones({bus.req_write, bus.req_read, hold, scan_done, timeout_err}) == 1), 64'd1);
          if (exp_q.size() == 0) check_eq("unexpected_event", 64'(obs), 64'd0);
          else check_eq("event", 64'(obs), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_force(input bit check_lat);
    @(posedge clk);
    #1 force_scan = 1'b1;
    @(posedge clk);
    #1 force_scan = 1'b0;
    if (check_lat) check_eq("start_to_req_write", 64'(bus.req_write), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bus"}, 64'({bus.req_addr, bus.req_data, bus.req_write, bus.req_read}), 64'd0);
    check_eq({tag, "_bank"}, 64'({wr_data, hold, busy, scan_done, timeout_err}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    int sz;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    check_eq("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_release");

    // Basic scan with 3-cycle bus latency
    rsp_delay = 3;
    base = done_count;
    push_scan();
    pulse_force(1'b1);
    wait_drain("scan_basic", 400);
    check_eq("scan_basic_done_count", 64'(done_count - base), 64'd1);

    // Zero-wait scan length
    rsp_delay = 1;
    push_scan();
    pulse_force(1'b1);
    wait_drain("scan_fast", 200);
    check_eq("scan_fast_length", 64'(last_done_cyc - last_wr_cyc), 64'd29);

    // Periodic scans, then enable low stops new ones
    rsp_delay = 1;
    base = wr_count;
    for (int i = 0; i < 3; i++) push_scan();
    @(posedge clk);
    #1 enable = 1'b1;
    n = 0;
    while (wr_count < base + 3 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1 enable = 1'b0;
    check_eq("periodic_starts", 64'(wr_count - base), 64'd3);
    sz = wr_cycs.size();
    if (sz >= 3) begin
      check_eq("periodic_gap_1", 64'(wr_cycs[sz-2] - wr_cycs[sz-3]), 64'(REFRESH));
      check_eq("periodic_gap_2", 64'(wr_cycs[sz-1] - wr_cycs[sz-2]), 64'(REFRESH));
    end
    wait_drain("periodic", 200);
    repeat (3 * REFRESH) @(posedge clk);
    #1;
    check_eq("disabled_no_scan", 64'(wr_count - base), 64'd3);

    // Two force pulses during an active scan -> exactly one extra scan
    rsp_delay = 3;
    base = done_count;
    push_scan();
    push_scan();
    pulse_force(1'b1);
    repeat (10) @(posedge clk);
    pulse_force(1'b0);
    repeat (5) @(posedge clk);
    pulse_force(1'b0);
    wait_drain("double_force", 1000);
    repeat (60) @(posedge clk);
    #1;
    check_eq("double_force_scans", 64'(done_count - base), 64'd2);

    // Timeout on the read of 8'h23
    rsp_delay = 3;
    drop_addr = 8'h23;
    base = done_count;
    exp_q.push_back(ev(4'd1, 8'hF0, 8'hF2, 9'd0));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ev(4'd2, tb_addr[i], 8'h00, 9'd0));
      exp_q.push_back(ev(4'd3, 8'h00, 8'(8'h10 + i), 9'(9'd1 << i)));
    end
    exp_q.push_back(ev(4'd2, 8'h23, 8'h00, 9'd0));
    exp_q.push_back(ev(4'd5, 8'h00, 8'h00, 9'd0));
    pulse_force(1'b1);
    wait_drain("timeout", 300);
    check_eq("timeout_wait_cycles", 64'(last_to_cyc - last_rd_cyc), 64'(TIMEOUT));
    check_eq("timeout_no_scan_done", 64'(done_count - base), 64'd0);
    check_eq("timeout_keeps_wr_data", 64'(wr_data), 64'h11);
    drop_addr = 8'h00;

    // Spurious bus_done in IDLE
    @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("spur_idle_busy", 64'(busy), 64'd0);

    // Spurious bus_done held into each STORE
    rsp_delay = 1;
    spur_store = 1'b1;
    push_scan();
    pulse_force(1'b1);
    wait_drain("spur_store", 300);
    spur_store = 1'b0;

    // Reset while waiting on the second read
    rsp_delay = 3;
    base = rd_count;
    push_scan();
    pulse_force(1'b1);
    n = 0;
    while (rd_count < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_eq("pre_reset_state", 64'(state_dbg), 64'(ST_RD_WAIT));
    rst_gen++;
    reset = 1'b0;
    #1;
    check_all_zero("mid_scan_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("after_release_quiet", 64'({bus.req_write, bus.req_read, hold}), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("after_release_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Recovery scan after reset
    push_scan();
    pulse_force(1'b1);
    wait_drain("recovery", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
